univ_shift_reg: RTL

//  Parametrised universal storage register: a WIDTH-bit edge-triggered bank with hold, parallel load,

---
 rtl/univ_shift_reg.sv | 70 +++++++
 1 files changed

// File: rtl/univ_shift_reg.sv
// univ_shift_reg: universal register with hold, load, shift, rotate and clear, plus FSM-driven burst shifts.
module univ_shift_reg #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             en_in,
  input  logic             start_in,
  input  logic [2:0]       mode_in,
  input  logic [AMT_W-1:0] amt_in,
  input  logic [WIDTH-1:0] d_in,
  input  logic             ser_r_in,
  input  logic             ser_l_in,
  output logic [WIDTH-1:0] q_out,
  output logic             ser_l_out,
  output logic             ser_r_out,
  output logic             busy_out,
  output logic             done_out
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state;
  logic [2:0]       op;
  logic [2:0]       sel;
  logic [AMT_W-1:0] rem;
  logic [WIDTH-1:0] nxt;
  logic             shift_mode;
  assign sel        = (state == RUN) ? op : mode_in;
  assign shift_mode = (mode_in >= 3'd2) && (mode_in <= 3'd6);
  assign ser_l_out  = q_out[WIDTH-1];
  assign ser_r_out  = q_out[0];
  assign busy_out   = (state == RUN);
  assign done_out   = (state == DONE);
  always_comb begin
    nxt = (sel == 3'd1) ? d_in :
          (sel == 3'd2) ? {q_out[WIDTH-2:0], ser_r_in} :
          (sel == 3'd3) ? {ser_l_in, q_out[WIDTH-1:1]} :
          (sel == 3'd4) ? {q_out[WIDTH-2:0], q_out[WIDTH-1]} :
          (sel == 3'd5) ? {q_out[0], q_out[WIDTH-1:1]} :
          (sel == 3'd6) ? {q_out[WIDTH-1], q_out[WIDTH-1:1]} :
          (sel == 3'd7) ? '0 : q_out;
  end
  // Bursts of one step, and non-shift starts, go straight to DONE; amt_in==0 leaves q untouched.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      q_out <= RESET_VAL;
      state <= IDLE;
      rem   <= '0;
      op    <= '0;
    end else if (state == RUN) begin
      q_out <= nxt;
      rem   <= rem - AMT_W'(1);
      if (rem == AMT_W'(1)) state <= DONE;
    end else if (start_in) begin
      if (shift_mode && amt_in >= AMT_W'(2)) begin
        q_out <= nxt;
        op    <= mode_in;
        rem   <= amt_in - AMT_W'(1);
        state <= RUN;
      end else begin
        if (amt_in != '0) q_out <= nxt;
        state <= DONE;
      end
    end else begin
      if (en_in) q_out <= nxt;
      state <= IDLE;
    end
  end
endmodule
